uart_input_buffer: RTL and testbench
====================================

UART_INPUT_BUFFER -- requirements
Module: uart_input_buffer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per serial bit (legal range 4 or more).
REQ-002 SHALL have parameter FIFO_DEPTH_LOG2, default 4, meaning log2 of the FIFO depth in bytes (default depth 16).
REQ-003 SHALL have port CLK, input, 1 bit, the clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high, clock is CLK.
REQ-005 SHALL have port rxd, input, 1 bit, the asynchronous serial receive line (idle high).
REQ-006 SHALL have port input_consume, input, 1 bit, a one-cycle pop request from the write-back stage.
REQ-007 SHALL have port clear_errors, input, 1 bit, which clears the sticky error flags.
REQ-008 SHALL have port input_ready, output, 1 bit, high when the FIFO is non-empty.
REQ-009 SHALL have port input_data, output, 32 bits, the FIFO head byte zero-extended to 32 bits.
REQ-010 SHALL have port fifo_count, output, FIFO_DEPTH_LOG2+1 bits, the number of bytes held.
REQ-011 SHALL have port overflow, output, 1 bit, sticky: a byte was dropped because the FIFO was full.
REQ-012 SHALL have port frame_error, output, 1 bit, sticky: a byte was dropped because its stop bit was 0.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer; all receiver decisions use only the synchronized value (rx_s).
REQ-014 Receiver FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: rx_s==0 SHALL move to START and load the bit timer with CLKS_PER_BIT/2 (floor).
REQ-016 START: on timer expiry, rx_s==0 SHALL move to DATA with the timer set to CLKS_PER_BIT; rx_s==1 (glitch) SHALL return to IDLE with no other effect.
REQ-017 DATA: each timer expiry SHALL sample rx_s into the shift register LSB first and reload CLKS_PER_BIT; after the 8th sample SHALL move to STOP.
REQ-018 STOP: on timer expiry, rx_s==1 SHALL push the byte and return to IDLE; rx_s==0 SHALL set frame_error, push nothing, and move to WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL return to IDLE on the first cycle rx_s==1.
REQ-020 A pushed byte SHALL be visible on input_data/input_ready in the cycle after the stop-bit sample edge, i.e. push latency is 1 cycle.
REQ-021 FIFO SHALL be circular with wrap-around read/write pointers of FIFO_DEPTH_LOG2 bits; fifo_count SHALL range 0..2^FIFO_DEPTH_LOG2.
REQ-022 input_consume while input_ready==1 SHALL pop the head, with the new head/count visible the next cycle; input_consume while empty SHALL be ignored.
REQ-023 When empty, input_data SHALL be 32'h0 and input_ready SHALL be 0.
REQ-024 Push while full and no pop SHALL drop the byte, leave the FIFO unchanged, and set overflow.
REQ-025 Simultaneous push and pop SHALL keep the count unchanged, including when full, and SHALL NOT set overflow.
REQ-026 clear_errors SHALL clear overflow and frame_error next cycle; a same-cycle set event SHALL take priority (flag stays 1).
REQ-027 clear_errors SHALL NOT affect FIFO contents or receiver state.

Reset
REQ-028 On reset SHALL force: FSM=IDLE; pointers, fifo_count, shift register, and timer = 0; synchronizer flops = 1; input_ready=0; input_data=0; overflow=0; frame_error=0.
REQ-029 Reset asserted mid-frame SHALL abandon the partial byte; no push SHALL occur for that frame after release.
REQ-030 Reset SHALL take priority over every other input in the same cycle.

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH_LOG2=2)
REQ-031 Send frame 0x5A (start, 0,1,0,1,1,0,1,0 LSB first, stop=1) -> input_ready=1, input_data=32'h0000005A, fifo_count=1; then pulse input_consume -> input_ready=0, input_data=0.
REQ-032 Send 5 bytes 0x01..0x05 with no consume -> fifo_count=4, overflow=1; pops return 0x01,0x02,0x03,0x04 in order.
REQ-033 With the FIFO full, input_consume coincides with a push of 0x77 -> fifo_count stays 4, overflow stays 0, 0x77 becomes the last entry.
REQ-034 Frame with stop bit 0 -> frame_error=1, fifo_count unchanged; a following good frame 0x33 after the line returns high -> 0x33 received; clear_errors -> frame_error=0.
REQ-035 rxd low pulse of 1 cycle while idle -> FSM returns to IDLE and fifo_count=0; reset asserted during the DATA bits of 0xC3 -> fifo_count=0, no byte after release.
REQ-036 Fill 6 bytes with interleaved pops, forcing pointer wrap -> data order preserved and fifo_count correct every cycle.

Source files
------------

// File: rtl/uart_input_buffer.sv
// UART receiver (8N1, mid-bit sampling) feeding a circular byte FIFO that the
// write-back stage drains one byte per input_consume pulse.
module uart_input_buffer #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     rxd,
  input  logic                     input_consume,
  input  logic                     clear_errors,
  output logic                     input_ready,
  output logic [31:0]              input_data,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     overflow,
  output logic                     frame_error
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int TW    = $clog2(CLKS_PER_BIT + 1);
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  logic                       rx_meta_q, rx_s_q;
  state_t                     state_q, state_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [7:0]                 shift_q, shift_d;
  logic [2:0]                 bit_cnt_q, bit_cnt_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic                       frame_error_q, frame_error_d;
  logic [7:0]                 mem [DEPTH];

  logic tick, push, ferr_set, ovf_set, pop, wr_en, full, empty;

  always_ff @(posedge CLK) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_s_q    <= rx_meta_q;
    end
  end

  // The timer counts down and "expires" on the cycle it reads 1, so a load of
  // N yields exactly N cycles between samples.
  assign tick = (timer_q == TW'(1));

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          timer_d = T_HALF;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s_q) begin
            state_d   = DATA;
            timer_d   = T_FULL;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = IDLE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          timer_d   = T_FULL;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          timer_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = input_consume && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);
    overflow_d    = ovf_set  | (overflow_q    & ~clear_errors);
    frame_error_d = ferr_set | (frame_error_q & ~clear_errors);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      frame_error_q <= frame_error_d;
    end
  end

  // The completed byte is shift_d, so the push lands on the stop-sample edge.
  always_ff @(posedge CLK) begin
    if (!reset && wr_en) mem[wr_ptr_q] <= shift_d;
  end

  assign input_ready = !empty;
  assign input_data  = empty ? 32'h0 : {24'h0, mem[rd_ptr_q]};
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_input_buffer.sv
// Scoreboard bench for uart_input_buffer: bytes expected in the FIFO are queued
// as frames are driven and compared as they are popped.
module tb_uart_input_buffer;

  localparam int N  = 4;
  localparam int L2 = 2;
  localparam int DEPTH = 1 << L2;

  logic        CLK = 1'b0;
  logic        reset, rxd, input_consume, clear_errors;
  logic        input_ready, overflow, frame_error;
  logic [31:0] input_data;
  logic [L2:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];
  int   model_cnt = 0;
  logic model_ovf = 1'b0;
  logic model_ferr = 1'b0;

  uart_input_buffer #(.CLKS_PER_BIT(N), .FIFO_DEPTH_LOG2(L2)) dut (
    .CLK(CLK), .reset(reset), .rxd(rxd), .input_consume(input_consume),
    .clear_errors(clear_errors), .input_ready(input_ready),
    .input_data(input_data), .fifo_count(fifo_count),
    .overflow(overflow), .frame_error(frame_error)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_head();
    return (model_cnt > 0) ? {24'h0, exp_q[0]} : 32'h0;
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, "_count"}, 32'(fifo_count), 32'(model_cnt));
    check_eq({tag, "_ready"}, 32'(input_ready), 32'(model_cnt > 0));
    check_eq({tag, "_data"}, input_data, exp_head());
    check_eq({tag, "_ovf"}, 32'(overflow), 32'(model_ovf));
    check_eq({tag, "_ferr"}, 32'(frame_error), 32'(model_ferr));
  endtask

  // Drives one frame, optionally pulsing consume/clear on the push edge, and
  // optionally asserting reset from data-frame bit rst_bit until the frame ends.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                           input logic do_pop, input logic do_clear, input int rst_bit);
    logic [9:0] frame;
    logic aborted, popped, good, was_full, ovf_set, ferr_set;
    frame   = {stop_bit, b, 1'b0};
    aborted = 1'b0;
    for (int bi = 0; bi < 10; bi++) begin
      for (int c = 0; c < N; c++) begin
        @(negedge CLK);
        check_eq("count_cyc", 32'(fifo_count), 32'(model_cnt));
        if (c == 0) begin
          rxd = frame[bi];
          if (bi == rst_bit) begin
            reset = 1'b1;
            aborted = 1'b1;
            exp_q.delete();
            model_cnt = 0;
            model_ovf = 1'b0;
            model_ferr = 1'b0;
          end
        end
      end
    end
    @(negedge CLK);
    check_eq("count_cyc", 32'(fifo_count), 32'(model_cnt));
    if (do_pop && model_cnt > 0) check_eq("pop_head", input_data, exp_head());
    rxd = 1'b1;
    reset = 1'b0;
    input_consume = do_pop;
    clear_errors = do_clear;
    @(negedge CLK);
    input_consume = 1'b0;
    clear_errors = 1'b0;
    popped   = do_pop && (model_cnt > 0);
    good     = !aborted && stop_bit;
    was_full = (model_cnt == DEPTH);
    ovf_set  = good && was_full && !popped;
    ferr_set = !aborted && !stop_bit;
    if (popped) begin
      void'(exp_q.pop_front());
      model_cnt--;
    end
    if (good && !ovf_set) begin
      exp_q.push_back(b);
      model_cnt++;
    end
    model_ovf  = ovf_set  | (model_ovf  & !do_clear);
    model_ferr = ferr_set | (model_ferr & !do_clear);
    check_state("frame");
    $display("frame %02h stop=%0b pop=%0b clr=%0b rst=%0d -> count=%0d ovf=%0b ferr=%0b",
             b, stop_bit, do_pop, do_clear, rst_bit, fifo_count, overflow, frame_error);
  endtask

  task automatic pop_byte();
    @(negedge CLK);
    check_eq("pop_ready", 32'(input_ready), 32'(model_cnt > 0));
    check_eq("pop_data", input_data, exp_head());
    $display("pop data=%08h count=%0d", input_data, fifo_count);
    input_consume = 1'b1;
    @(negedge CLK);
    input_consume = 1'b0;
    if (model_cnt > 0) begin
      void'(exp_q.pop_front());
      model_cnt--;
    end
    check_state("after_pop");
  endtask

  task automatic clear_err();
    @(negedge CLK);
    clear_errors = 1'b1;
    @(negedge CLK);
    clear_errors = 1'b0;
    model_ovf = 1'b0;
    model_ferr = 1'b0;
    check_state("clear");
    $display("clear_errors -> ovf=%0b ferr=%0b", overflow, frame_error);
  endtask

  initial begin
    reset = 1'b1;
    rxd = 1'b1;
    input_consume = 1'b0;
    clear_errors = 1'b0;
    repeat (3) @(negedge CLK);
    check_state("reset");
    reset = 1'b0;

    // One-cycle low glitch while idle must not produce a byte.
    @(negedge CLK); rxd = 1'b0;
    @(negedge CLK); rxd = 1'b1;
    repeat (12) begin
      @(negedge CLK);
      check_eq("glitch_count", 32'(fifo_count), 32'd0);
    end
    $display("glitch -> count=%0d", fifo_count);

    send_byte(8'h5A, 1'b1, 1'b0, 1'b0, -1);
    pop_byte();
    pop_byte();   // consume while empty is ignored

    // Overflow: fifth byte dropped; clear in the same cycle loses to the set.
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 1'b0, 1'b0, -1);
    send_byte(8'h05, 1'b1, 1'b0, 1'b1, -1);
    clear_err();

    // Full FIFO with simultaneous pop and push.
    send_byte(8'h77, 1'b1, 1'b1, 1'b0, -1);
    while (model_cnt > 0) pop_byte();

    // Bad stop bit, then a good frame, then clear.
    send_byte(8'h99, 1'b0, 1'b0, 1'b0, -1);
    repeat (2) @(negedge CLK);
    send_byte(8'h33, 1'b1, 1'b0, 1'b0, -1);
    pop_byte();
    clear_err();

    // Interleaved pushes and pops across the pointer wrap.
    for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 1'b1, 1'(i % 2), 1'b0, -1);
    while (model_cnt > 0) pop_byte();

    // Reset in the middle of the data bits of 0xC3.
    send_byte(8'h11, 1'b1, 1'b0, 1'b0, -1);
    send_byte(8'hC3, 1'b1, 1'b0, 1'b0, 3);
    repeat (30) begin
      @(negedge CLK);
      check_eq("post_rst_count", 32'(fifo_count), 32'd0);
    end
    check_state("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
